// File: rtl/sdram_uart_pkg.sv
// sdram_uart_pkg: constants shared by the UART command decoder and response encoder.
// RESP_CKSUM_EN adds the checksum states and lengthens the frame by one byte.
package sdram_uart_pkg;
  localparam logic [7:0] CMD_WR = 8'h55;
  localparam logic [7:0] CMD_RD = 8'hAA;
  localparam logic [7:0] RESP_HEAD = 8'h5A;
  localparam int RD_BYTES_DEF = 4;
`ifdef RESP_CKSUM_EN
  localparam int FRAME_LEN = RD_BYTES_DEF + 2;
  typedef enum logic [3:0] {IDLE, HEAD, WAIT_H, POP, LOAD, WAIT_D, CKSUM, WAIT_C, DONE} resp_state_t;
`else
  localparam int FRAME_LEN = RD_BYTES_DEF + 1;
  typedef enum logic [3:0] {IDLE, HEAD, WAIT_H, POP, LOAD, WAIT_D, DONE} resp_state_t;
`endif
endpackage

// File: rtl/uart_resp_encode.sv
// uart_resp_encode: drains an SDRAM read burst from the FIFO and frames it for UART TX.
// Optional RESP_CKSUM_EN appends the XOR of the payload bytes after the payload.
module uart_resp_encode
  import sdram_uart_pkg::*;
#(
  parameter int RD_BYTES = RD_BYTES_DEF,
  parameter logic [7:0] RESP_HEAD = sdram_uart_pkg::RESP_HEAD
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       rd_done,
  input  logic       rfifo_empty,
  input  logic [7:0] rfifo_rd_data,
  output logic       rfifo_rd_en,
  input  logic       tx_done,
  output logic       tx_trig,
  output logic [7:0] tx_data,
  output logic       resp_busy
);
  localparam logic [3:0] LAST = 4'(RD_BYTES);
  resp_state_t state, nxt;
  logic [3:0] cnt, cnt_d;
  logic rd_en_d, trig_d, busy_d, ack;
  logic [7:0] data_d;
`ifdef RESP_CKSUM_EN
  logic [7:0] sum, sum_d;
`endif
  // a done pulse landing on the trigger cycle belongs to the previous byte
  assign ack = tx_done && !tx_trig;
  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state <= IDLE;
      cnt <= '0;
      rfifo_rd_en <= 1'b0;
      tx_trig <= 1'b0;
      tx_data <= '0;
      resp_busy <= 1'b0;
`ifdef RESP_CKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      rfifo_rd_en <= rd_en_d;
      tx_trig <= trig_d;
      tx_data <= data_d;
      resp_busy <= busy_d;
`ifdef RESP_CKSUM_EN
      sum <= sum_d;
`endif
    end
  end
  // POP leaves only once the registered pop strobe is up, so LOAD sees valid data
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   nxt = rd_done ? HEAD : IDLE;
      HEAD:   nxt = WAIT_H;
      WAIT_H: nxt = ack ? POP : WAIT_H;
      POP:    nxt = rfifo_rd_en ? LOAD : POP;
      LOAD:   nxt = WAIT_D;
`ifdef RESP_CKSUM_EN
      WAIT_D: nxt = !ack ? WAIT_D : (cnt < LAST) ? POP : CKSUM;
      CKSUM:  nxt = WAIT_C;
      WAIT_C: nxt = ack ? DONE : WAIT_C;
`else
      WAIT_D: nxt = !ack ? WAIT_D : (cnt < LAST) ? POP : DONE;
`endif
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // a stale not-empty is safe: only this block pops, so the FIFO cannot drain meanwhile
  always_comb begin
    rd_en_d = (nxt == POP) && !rfifo_empty;
    busy_d = (state == IDLE && rd_done) ? 1'b1 : (state == DONE) ? 1'b0 : resp_busy;
    cnt_d = (state == DONE) ? 4'd0 : (state == LOAD) ? cnt + 4'd1 : cnt;
`ifdef RESP_CKSUM_EN
    trig_d = state inside {HEAD, LOAD, CKSUM};
    data_d = (state == HEAD) ? RESP_HEAD : (state == LOAD) ? rfifo_rd_data : (state == CKSUM) ? sum : tx_data;
    sum_d = (state == HEAD) ? 8'h00 : (state == LOAD) ? sum ^ rfifo_rd_data : sum;
`else
    trig_d = state inside {HEAD, LOAD};
    data_d = (state == HEAD) ? RESP_HEAD : (state == LOAD) ? rfifo_rd_data : tx_data;
`endif
  end
endmodule

// File: tb/tb_uart_resp_encode.sv
// tb_uart_resp_encode: randomized frame tests against a queue-based frame model.
// Honours RESP_CKSUM_EN by appending the payload XOR to every expected frame.
module tb_uart_resp_encode;
  localparam int NB = 4;
  typedef logic [7:0] bq_t[$];
  logic sclk = 1'b0, s_rst = 1'b1, rd_done = 1'b0;
  logic rfifo_empty = 1'b1;
  logic [7:0] rfifo_rd_data = 8'h00;
  logic rfifo_rd_en, tx_trig, resp_busy, tx_done;
  logic [7:0] tx_data;
  logic done_m = 1'b0, done_s = 1'b0;
  logic flush = 1'b0;
  int n_vec = 0, n_err = 0;
  int cyc = 0, pops = 0, overlap = 0, underrun = 0, cd = 0, tx_lat = 10;
  logic [7:0] fq[$], pend[$], sent[$];
  int trig_cyc[$], done_cyc[$];
  assign tx_done = done_m | done_s;
  always #5 sclk = ~sclk;
  uart_resp_encode #(.RD_BYTES(NB)) dut (
    .sclk(sclk), .s_rst(s_rst), .rd_done(rd_done), .rfifo_empty(rfifo_empty),
    .rfifo_rd_data(rfifo_rd_data), .rfifo_rd_en(rfifo_rd_en), .tx_done(tx_done),
    .tx_trig(tx_trig), .tx_data(tx_data), .resp_busy(resp_busy)
  );
  // FIFO model: data appears the cycle after the pop strobe
  always @(posedge sclk) begin
    if (rfifo_rd_en) begin
      if (fq.size() == 0) underrun++;
      else rfifo_rd_data <= fq.pop_front();
    end
    if (flush) fq.delete();
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    rfifo_empty <= (fq.size() == 0);
  end
  // UART TX model and monitor
  always @(negedge sclk) begin
    cyc++;
    done_m = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        done_m = 1'b1;
        done_cyc.push_back(cyc);
      end
    end
    if (tx_trig) begin
      sent.push_back(tx_data);
      trig_cyc.push_back(cyc);
      cd = tx_lat;
    end
    if (rfifo_rd_en) pops++;
    if (rfifo_rd_en && tx_trig) overlap++;
  end
  function automatic bq_t frame(bq_t pl);
    bq_t e;
    logic [7:0] x = 8'h00;
    e.push_back(8'h5A);
    foreach (pl[i]) begin
      e.push_back(pl[i]);
      x = x ^ pl[i];
    end
`ifdef RESP_CKSUM_EN
    e.push_back(x);
`endif
    return e;
  endfunction
  function automatic bq_t rand_pl(int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(0, 255)));
    return p;
  endfunction
  task automatic tick;
    @(negedge sclk);
    #1;
  endtask
  task automatic push(bq_t d);
    foreach (d[i]) pend.push_back(d[i]);
  endtask
  task automatic pulse_rd;
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
  endtask
  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!resp_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic wait_sent(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sent.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset;
    s_rst = 1'b1;
    repeat (3) tick();
    n_vec++; if (rfifo_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", rfifo_rd_en); end
    n_vec++; if (tx_trig !== 1'b0) begin n_err++; $display("FAIL reset_trig: got %b want 0", tx_trig); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", tx_data); end
    n_vec++; if (resp_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", resp_busy); end
    s_rst = 1'b0;
    repeat (3) tick();
    n_vec++; if (resp_busy !== 1'b0 || tx_trig !== 1'b0) begin n_err++; $display("FAIL reset_release: busy=%b trig=%b want 0 0", resp_busy, tx_trig); end
  endtask
  task automatic test_basic;
    bq_t pl, e;
    int b, p0, tb0, db0;
    bit ok;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    e = frame(pl);
    tx_lat = 10;
    b = sent.size(); p0 = pops; tb0 = trig_cyc.size(); db0 = done_cyc.size();
    push(pl);
    tick(); tick();
    pulse_rd();
    n_vec++; if (resp_busy !== 1'b1 || tx_trig !== 1'b0) begin n_err++; $display("FAIL basic_busy_rise: busy=%b trig=%b want 1 0", resp_busy, tx_trig); end
    tick();
    n_vec++; if (tx_trig !== 1'b1 || tx_data !== 8'h5A) begin n_err++; $display("FAIL basic_head: trig=%b data=%h want 1 5a", tx_trig, tx_data); end
    wait_idle(500, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_timeout: busy=%b want 0", resp_busy); end
    n_vec++; if (sent.size() - b != e.size()) begin n_err++; $display("FAIL basic_len: got %0d want %0d", sent.size() - b, e.size()); end
    for (int i = 0; i < e.size(); i++)
      if (b + i < sent.size()) begin
        n_vec++; if (sent[b+i] !== e[i]) begin n_err++; $display("FAIL basic_byte%0d: got %h want %h", i, sent[b+i], e[i]); end
      end
    n_vec++; if (pops - p0 != NB) begin n_err++; $display("FAIL basic_pops: got %0d want %0d", pops - p0, NB); end
    for (int i = 1; i <= NB; i++)
      if (tb0 + i < trig_cyc.size() && db0 + i - 1 < done_cyc.size()) begin
        n_vec++; if (trig_cyc[tb0+i] - done_cyc[db0+i-1] != 3) begin n_err++; $display("FAIL basic_lat%0d: got %0d want 3", i, trig_cyc[tb0+i] - done_cyc[db0+i-1]); end
      end
    if (done_cyc.size() > db0) begin
      n_vec++; if (cyc - done_cyc[done_cyc.size()-1] != 2) begin n_err++; $display("FAIL basic_busy_fall: got %0d want 2", cyc - done_cyc[done_cyc.size()-1]); end
    end
  endtask
  task automatic test_underrun;
    bq_t pl, e;
    int b, p0;
    bit ok;
    pl = rand_pl(NB);
    e = frame(pl);
    tx_lat = 10;
    b = sent.size(); p0 = pops;
    push('{pl[0], pl[1]});
    tick(); tick();
    pulse_rd();
    repeat (47) tick();
    n_vec++; if (pops - p0 != 2) begin n_err++; $display("FAIL underrun_hold_pops: got %0d want 2", pops - p0); end
    n_vec++; if (sent.size() - b != 3 || resp_busy !== 1'b1) begin n_err++; $display("FAIL underrun_hold: sent=%0d busy=%b want 3 1", sent.size() - b, resp_busy); end
    push('{pl[2], pl[3]});
    wait_idle(500, ok);
    n_vec++; if (!ok || sent.size() - b != e.size()) begin n_err++; $display("FAIL underrun_len: ok=%b got %0d want %0d", ok, sent.size() - b, e.size()); end
    for (int i = 0; i < e.size(); i++)
      if (b + i < sent.size()) begin
        n_vec++; if (sent[b+i] !== e[i]) begin n_err++; $display("FAIL underrun_byte%0d: got %h want %h", i, sent[b+i], e[i]); end
      end
    n_vec++; if (pops - p0 != NB) begin n_err++; $display("FAIL underrun_pops: got %0d want %0d", pops - p0, NB); end
  endtask
  task automatic test_ignored;
    bq_t pl, e;
    int b, p0;
    bit ok;
    pl = rand_pl(NB);
    e = frame(pl);
    tx_lat = $urandom_range(4, 12);
    b = sent.size(); p0 = pops;
    done_s = 1'b1; tick(); done_s = 1'b0;
    tick();
    n_vec++; if (resp_busy !== 1'b0 || sent.size() != b) begin n_err++; $display("FAIL ignored_idle_done: busy=%b sent=%0d want 0 0", resp_busy, sent.size() - b); end
    pulse_rd();
    wait_sent(b + 1, 50, ok);
    repeat (tx_lat + 6) tick();
    pulse_rd();
    done_s = 1'b1; tick(); done_s = 1'b0;
    repeat (5) tick();
    n_vec++; if (!ok || sent.size() - b != 1 || pops != p0) begin n_err++; $display("FAIL ignored_pop_hold: sent=%0d pops=%0d want 1 0", sent.size() - b, pops - p0); end
    push(pl);
    wait_idle(500, ok);
    repeat (40) tick();
    n_vec++; if (!ok || sent.size() - b != e.size() || resp_busy !== 1'b0) begin n_err++; $display("FAIL ignored_len: sent=%0d busy=%b want %0d 0", sent.size() - b, resp_busy, e.size()); end
    for (int i = 0; i < e.size(); i++)
      if (b + i < sent.size()) begin
        n_vec++; if (sent[b+i] !== e[i]) begin n_err++; $display("FAIL ignored_byte%0d: got %h want %h", i, sent[b+i], e[i]); end
      end
    n_vec++; if (pops - p0 != NB) begin n_err++; $display("FAIL ignored_pops: got %0d want %0d", pops - p0, NB); end
  endtask
  task automatic test_reset_mid;
    bq_t pl, e;
    int b, p0;
    bit ok;
    tx_lat = 10;
    b = sent.size();
    push(rand_pl(NB));
    tick(); tick();
    pulse_rd();
    wait_sent(b + 3, 200, ok);
    repeat (3) tick();
    #2 s_rst = 1'b1;
    #1;
    n_vec++; if (!ok || rfifo_rd_en !== 1'b0 || tx_trig !== 1'b0 || tx_data !== 8'h00 || resp_busy !== 1'b0)
      begin n_err++; $display("FAIL midreset_async: ok=%b rd_en=%b trig=%b data=%h busy=%b want 1 0 0 00 0", ok, rfifo_rd_en, tx_trig, tx_data, resp_busy); end
    tick();
    s_rst = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (15) tick();
    pl = rand_pl(NB);
    e = frame(pl);
    b = sent.size(); p0 = pops;
    push(pl);
    tick(); tick();
    pulse_rd();
    wait_idle(500, ok);
    n_vec++; if (!ok || sent.size() - b != e.size()) begin n_err++; $display("FAIL midreset_len: ok=%b got %0d want %0d", ok, sent.size() - b, e.size()); end
    for (int i = 0; i < e.size(); i++)
      if (b + i < sent.size()) begin
        n_vec++; if (sent[b+i] !== e[i]) begin n_err++; $display("FAIL midreset_byte%0d: got %h want %h", i, sent[b+i], e[i]); end
      end
    n_vec++; if (pops - p0 != NB) begin n_err++; $display("FAIL midreset_pops: got %0d want %0d", pops - p0, NB); end
  endtask
  task automatic test_back_to_back;
    bq_t pl, e, e2;
    int b, p0;
    bit ok1, ok2;
    pl = rand_pl(2 * NB);
    e = frame(pl[0:NB-1]);
    e2 = frame(pl[NB:2*NB-1]);
    foreach (e2[i]) e.push_back(e2[i]);
    tx_lat = $urandom_range(3, 9);
    b = sent.size(); p0 = pops;
    push(pl);
    tick(); tick();
    pulse_rd();
    wait_idle(500, ok1);
    pulse_rd();
    n_vec++; if (resp_busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: busy=%b want 1", resp_busy); end
    wait_idle(500, ok2);
    n_vec++; if (!ok1 || !ok2 || sent.size() - b != e.size()) begin n_err++; $display("FAIL b2b_len: ok=%b%b got %0d want %0d", ok1, ok2, sent.size() - b, e.size()); end
    for (int i = 0; i < e.size(); i++)
      if (b + i < sent.size()) begin
        n_vec++; if (sent[b+i] !== e[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, sent[b+i], e[i]); end
      end
    n_vec++; if (pops - p0 != 2 * NB) begin n_err++; $display("FAIL b2b_pops: got %0d want %0d", pops - p0, 2 * NB); end
  endtask
  task automatic test_cksum;
    bq_t pl, e;
    int b;
    bit ok;
    pl = '{8'h01, 8'h02, 8'h04, 8'h08};
    e = frame(pl);
    tx_lat = 6;
    b = sent.size();
    push(pl);
    tick(); tick();
    pulse_rd();
    wait_idle(500, ok);
    n_vec++; if (!ok || sent.size() - b != e.size()) begin n_err++; $display("FAIL cksum_len: ok=%b got %0d want %0d", ok, sent.size() - b, e.size()); end
    for (int i = 0; i < e.size(); i++)
      if (b + i < sent.size()) begin
        n_vec++; if (sent[b+i] !== e[i]) begin n_err++; $display("FAIL cksum_byte%0d: got %h want %h", i, sent[b+i], e[i]); end
      end
`ifdef RESP_CKSUM_EN
    if (sent.size() > b) begin
      n_vec++; if (sent[sent.size()-1] !== 8'h0F) begin n_err++; $display("FAIL cksum_value: got %h want 0f", sent[sent.size()-1]); end
    end
`endif
  endtask
  task automatic test_invariants;
    n_vec++; if (overlap != 0) begin n_err++; $display("FAIL overlap: got %0d want 0", overlap); end
    n_vec++; if (underrun != 0) begin n_err++; $display("FAIL empty_pop: got %0d want 0", underrun); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    test_cksum();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end
endmodule

// File: doc/uart_resp_encode.md
Name: uart_resp_encode

Overview:
- Transmit-side counterpart of the UART command decoder in the SDRAM test path.
- After an SDRAM read burst completes, the read FIFO holds RD_BYTES bytes. This block drains them and frames them for the UART transmitter.
- Frame format: header byte, then RD_BYTES payload bytes.
- Each byte is handed to the UART TX module with a trigger/done handshake, one byte at a time.

Parameters:
- RD_BYTES, 4, payload bytes per response frame (1..15).
- RESP_HEAD, 8'h5A, header byte sent first in every frame.

Ports:
- sclk  input  1  system clock.
- s_rst  input  1  asynchronous, active-high reset.
- rd_done  input  1  one-cycle pulse: SDRAM read finished; FIFO now holds the frame payload.
- rfifo_empty  input  1  read FIFO empty flag.
- rfifo_rd_data  input  8  FIFO read data, valid the cycle after rfifo_rd_en.
- rfifo_rd_en  output  1  one-cycle FIFO pop strobe.
- tx_done  input  1  one-cycle pulse from UART TX: current byte fully shifted out, stop bit included.
- tx_trig  output  1  one-cycle pulse: start transmitting tx_data.
- tx_data  output  8  byte to transmit; stable from tx_trig until the next tx_trig.
- resp_busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - rfifo_rd_en=0, tx_trig=0, tx_data=8'h00, resp_busy=0, byte counter=0.
  - Any partially sent frame is abandoned.
- All outputs are registered.
- States:
  - IDLE: on rd_done, go to HEAD and set resp_busy=1.
  - HEAD: tx_data<=RESP_HEAD, tx_trig=1 for one cycle, go to WAIT_H.
  - WAIT_H: wait for tx_done, then go to POP.
  - POP: if rfifo_empty=0, assert rfifo_rd_en for one cycle and go to LOAD. If empty, stay in POP with no pop and no timeout.
  - LOAD: FIFO data valid this cycle. tx_data<=rfifo_rd_data, tx_trig=1 for one cycle, counter increments, go to WAIT_D.
  - WAIT_D: on tx_done, go to POP if counter<RD_BYTES; otherwise go to DONE.
  - DONE: clear counter and resp_busy, return to IDLE. Exactly one cycle.
- Latency:
  - rd_done to header tx_trig: 2 cycles (rd_done sampled in IDLE; HEAD registers the trigger).
  - tx_done to next data tx_trig: 3 cycles (POP, LOAD, registered trigger), assuming the FIFO is not empty.
- Counter width: 4 bits. It never wraps, because RD_BYTES≤15.
- Boundary and simultaneous events:
  - rd_done outside IDLE (including DONE) is ignored. No queuing.
  - tx_done in IDLE, HEAD, POP or LOAD is ignored.
  - tx_done coincident with tx_trig cannot advance the FSM; only a tx_done seen in a WAIT state counts.
  - Exactly RD_BYTES pops per frame. Never a pop while rfifo_empty=1.
  - rfifo_rd_en and tx_trig are never high in the same cycle.
  - Back-to-back frames: a rd_done arriving one cycle after DONE starts a new frame normally.

Optional Feature:
- Macro: RESP_CKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is kept, cleared at HEAD. The header byte is excluded.
  - After the last WAIT_D, the FSM enters CKSUM instead of DONE. CKSUM sends the XOR value with tx_trig, then WAIT_C waits for tx_done, then DONE.
  - Frame length is RD_BYTES+2.
- Undefined:
  - No XOR register, no CKSUM or WAIT_C states.
  - Frame length is RD_BYTES+1.

Decomposition:
- Shared package (sdram_uart_pkg) holds:
  - State encoding constants.
  - RESP_HEAD and the command bytes used by the decoder (8'h55 write, 8'hAA read), so both ends share one definition.
  - Frame-length constant.
- No sub-module. A single FSM plus counter is natural. The UART TX itself stays a separate existing module.

Test Plan:
- Basic frame: FIFO preloaded 11,22,33,44. rd_done pulse; TX model returns tx_done 10 cycles after each tx_trig. Required: tx_data sequence 5A,11,22,33,44. Exactly 4 rfifo_rd_en pulses. resp_busy high from 1 cycle after rd_done until DONE.
- FIFO underrun: only 2 bytes present at rd_done; the remaining 2 are written 50 cycles later. Required: FSM holds in POP with no pop while empty, then completes 5A,b0,b1,b2,b3.
- Ignored events: second rd_done mid-frame, plus stray tx_done pulses in IDLE and POP. Required: a single 5-byte frame, no extra pops, no extra triggers.
- Reset mid-frame: assert s_rst during byte 2's WAIT_D. Required: all outputs 0 immediately (asynchronous). A following rd_done produces a fresh frame starting with 5A.
- Back-to-back: rd_done one cycle after DONE with 8 bytes in the FIFO. Required: two complete frames, counter restarts at 0.
- RESP_CKSUM_EN defined: payload 01,02,04,08. Required: transmitted sequence 5A,01,02,04,08,0F, then return to IDLE.
